// File: rtl/decode_group_stage_pkg.sv
// rtl/decode_group_stage_pkg.sv - shared types for the grouped decode stage
package decode_group_stage_pkg;

  localparam int LANES_MAX = 4;

  typedef enum logic [6:0] {
    NOP    = 7'b0000000,
    LOAD   = 7'b0000011,
    OP_IMM = 7'b0010011,
    AUIPC  = 7'b0010111,
    STORE  = 7'b0100011,
    OP     = 7'b0110011,
    LUI    = 7'b0110111,
    BRANCH = 7'b1100011,
    JALR   = 7'b1100111,
    JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [1:0] {
    B_RS2   = 2'd0,
    B_IMM_I = 2'd1,
    B_IMM_S = 2'd2,
    B_PC    = 2'd3
  } b_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    opcode_t     opcode;
    logic [3:0]  alu_fun;
    logic [1:0]  wb_sel;
    logic [2:0]  mem_type;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_used;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2_data;
  } task_t;

  typedef struct packed {
    logic [LANES_MAX-1:0]                lane_v;
    task_t [LANES_MAX-1:0]               tasks;
    logic [LANES_MAX-1:0]                illegal;
    logic [LANES_MAX-1:0][LANES_MAX-1:0] dep;
    logic [LANES_MAX-1:0]                a_sel;
    b_sel_t [LANES_MAX-1:0]              b_sel;
  } dec_group_t;

endpackage

// File: rtl/decode_group_stage_if.sv
// rtl/decode_group_stage_if.sv - fetch, writeback and task-group bus of the decode stage
interface decode_group_stage_if #(
  parameter int LANES    = 2,
  parameter int WB_PORTS = 1
);
  import decode_group_stage_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [LANES-1:0]               in_lane_v;
  logic [LANES-1:0][31:0]         in_pc;
  logic [LANES-1:0][31:0]         in_ir;
  logic [WB_PORTS-1:0]            wb_en;
  logic [WB_PORTS-1:0][4:0]       wb_addr;
  logic [WB_PORTS-1:0][31:0]      wb_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [LANES-1:0]               out_lane_v;
  task_t [LANES-1:0]              out_task;
  logic [LANES-1:0]               out_illegal;
  logic [LANES-1:0][LANES-1:0]    out_dep;

  modport master (
    output in_valid, in_lane_v, in_pc, in_ir, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_lane_v, out_task, out_illegal, out_dep
  );

  modport slave (
    input  in_valid, in_lane_v, in_pc, in_ir, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_lane_v, out_task, out_illegal, out_dep
  );

endinterface

// File: rtl/decode_group_stage_decoder.sv
// rtl/decode_group_stage_decoder.sv - single-lane instruction decode and operand muxing
module decode_group_stage_decoder
  import decode_group_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output task_t       tsk,
  output logic        illegal,
  output logic        a_sel,
  output b_sel_t      b_sel
);

  opcode_t     op;
  logic [2:0]  f3;
  logic        legal;
  logic [31:0] imm_i, imm_s, imm_u;

  assign op    = opcode_t'(ir[6:0]);
  assign f3    = ir[14:12];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_u = {ir[31:12], 12'd0};

  // Opcode legality, operand selects, and the decoded task fields
  always_comb begin
    legal = 1'b1;
    a_sel = 1'b0;
    b_sel = B_RS2;
    case (op)
      LUI:                 a_sel = 1'b1;
      AUIPC:               begin a_sel = 1'b1; b_sel = B_PC; end
      JAL, NOP, OP, BRANCH: ;
      JALR, LOAD, OP_IMM:  b_sel = B_IMM_I;
      STORE:               b_sel = B_IMM_S;
      default:             legal = 1'b0;
    endcase
    illegal = ~legal;

    tsk          = '0;
    tsk.pc       = pc;
    tsk.opcode   = op;
    tsk.mem_type = f3;
    tsk.rd_addr  = ir[11:7];
    tsk.rs1_addr = ir[19:15];
    tsk.rs2_addr = ir[24:20];
    tsk.alu_fun  = (op == OP)     ? {ir[30], f3} :
                   (op == OP_IMM) ? {(f3 == 3'b101) & ir[30], f3} :
                   (op == LUI)    ? 4'b1001 : 4'b0000;
    tsk.wb_sel   = (op == JAL || op == JALR) ? 2'd0 : (op == LOAD) ? 2'd2 : 2'd3;
    tsk.rd_used  = legal & (op != BRANCH) & (op != STORE) & (op != NOP);
    tsk.rs1_used = legal & (op != LUI) & (op != AUIPC) & (op != JAL) & (op != NOP);
    tsk.rs2_used = legal & ((op == BRANCH) | (op == STORE) | (op == OP));
    tsk.a        = a_sel ? imm_u : rs1_data;
    case (b_sel)
      B_IMM_I: tsk.b = imm_i;
      B_IMM_S: tsk.b = imm_s;
      B_PC:    tsk.b = pc;
      default: tsk.b = rs2_data;
    endcase
    tsk.rs2_data = rs2_data;
  end

endmodule

// File: rtl/decode_group_stage_regfile.sv
// rtl/decode_group_stage_regfile.sv - multiport register file with writeback bypass
module decode_group_stage_regfile #(
  parameter int RD_PORTS = 4,
  parameter int WB_PORTS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WB_PORTS-1:0]       wb_en,
  input  logic [WB_PORTS-1:0][4:0]  wb_addr,
  input  logic [WB_PORTS-1:0][31:0] wb_data,
  input  logic [4:0]                rd_addr [RD_PORTS],
  output logic [31:0]               rd_data [RD_PORTS]
);

  logic [31:0][31:0] mem;

  // Write ports in ascending order so the highest-indexed port wins; x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int w = 0; w < WB_PORTS; w++) begin
        if (wb_en[w] && wb_addr[w] != 5'd0) mem[wb_addr[w]] <= wb_data[w];
      end
    end
  end

  // Read with same-cycle bypass; the later (higher) port overrides earlier matches
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data[p] = (rd_addr[p] == 5'd0) ? 32'd0 : mem[rd_addr[p]];
      for (int w = 0; w < WB_PORTS; w++) begin
        if (wb_en[w] && wb_addr[w] != 5'd0 && wb_addr[w] == rd_addr[p]) rd_data[p] = wb_data[w];
      end
    end
  end

endmodule

// File: rtl/decode_group_stage.sv
// rtl/decode_group_stage.sv - N-lane decode stage with regfile bypass and skid buffer
module decode_group_stage
  import decode_group_stage_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int WB_PORTS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  decode_group_stage_if.slave bus
);

  localparam int RP = 2 * LANES;

  logic [4:0]  rd_addr [RP];
  logic [31:0] rd_data [RP];
  task_t       dec_task [LANES];
  logic        dec_ill  [LANES];
  logic        dec_asel [LANES];
  b_sel_t      dec_bsel [LANES];
  logic [LANES-1:0] eff_v;
  logic        run;

  logic        out_v, skid_v, accept, consume;
  dec_group_t  out_q, skid_q, out_ref, skid_ref, new_grp;

  // Writeback into a held group updates only operands that came from a matching source register
  function automatic dec_group_t refresh(input dec_group_t g,
                                         input logic [WB_PORTS-1:0] en,
                                         input logic [WB_PORTS-1:0][4:0] addr,
                                         input logic [WB_PORTS-1:0][31:0] data);
    dec_group_t r;
    r = g;
    for (int w = 0; w < WB_PORTS; w++) begin
      if (en[w] && addr[w] != 5'd0) begin
        for (int l = 0; l < LANES_MAX; l++) begin
          if (g.tasks[l].rs1_used && g.tasks[l].rs1_addr == addr[w] && !g.a_sel[l])
            r.tasks[l].a = data[w];
          if (g.tasks[l].rs2_used && g.tasks[l].rs2_addr == addr[w]) begin
            r.tasks[l].rs2_data = data[w];
            if (g.b_sel[l] == B_RS2) r.tasks[l].b = data[w];
          end
        end
      end
    end
    return r;
  endfunction

  decode_group_stage_regfile #(.RD_PORTS(RP), .WB_PORTS(WB_PORTS)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign rd_addr[2*l]   = bus.in_ir[l][19:15];
    assign rd_addr[2*l+1] = bus.in_ir[l][24:20];

    decode_group_stage_decoder u_dec (
      .pc       (bus.in_pc[l]),
      .ir       (bus.in_ir[l]),
      .rs1_data (rd_data[2*l]),
      .rs2_data (rd_data[2*l+1]),
      .tsk      (dec_task[l]),
      .illegal  (dec_ill[l]),
      .a_sel    (dec_asel[l]),
      .b_sel    (dec_bsel[l])
    );

    assign bus.out_lane_v[l]  = out_q.lane_v[l];
    assign bus.out_task[l]    = out_q.tasks[l];
    assign bus.out_illegal[l] = out_q.illegal[l];
    for (genvar i = 0; i < LANES; i++) begin : g_dep
      assign bus.out_dep[l][i] = out_q.dep[l][i];
    end
  end

  assign accept        = bus.in_valid & ~skid_v & ~flush;
  assign consume       = out_v & bus.out_ready;
  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = out_v;
  assign out_ref       = refresh(out_q, bus.wb_en, bus.wb_addr, bus.wb_data);
  assign skid_ref      = refresh(skid_q, bus.wb_en, bus.wb_addr, bus.wb_data);

  // Assemble the incoming group: lanes after the first invalid one drop out, then RAW masks
  always_comb begin
    new_grp = '0;
    run     = 1'b1;
    eff_v   = '0;
    for (int l = 0; l < LANES; l++) begin
      run                  = run & bus.in_lane_v[l];
      eff_v[l]             = run;
      new_grp.lane_v[l]    = run;
      new_grp.tasks[l]     = dec_task[l];
      new_grp.illegal[l]   = dec_ill[l];
      new_grp.a_sel[l]     = dec_asel[l];
      new_grp.b_sel[l]     = dec_bsel[l];
    end
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        new_grp.dep[j][i] = eff_v[i] & eff_v[j] & dec_task[i].rd_used &
                            (dec_task[i].rd_addr != 5'd0) &
                            ((dec_task[j].rs1_used & (dec_task[j].rs1_addr == dec_task[i].rd_addr)) |
                             (dec_task[j].rs2_used & (dec_task[j].rs2_addr == dec_task[i].rd_addr)));
      end
    end
  end

  // OUT/SKID occupancy and contents; flush wins, SKID drains into OUT before new input lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_ref;
      skid_q <= skid_ref;
      if (flush) begin
        out_v  <= 1'b0;
        skid_v <= 1'b0;
      end else if (!out_v || consume) begin
        if (skid_v) begin
          out_q  <= skid_ref;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else if (accept) begin
          out_q <= new_grp;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= new_grp;
        skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_group_stage.sv
// tb/tb_decode_group_stage.sv - directed self-checking bench for decode_group_stage
module tb_decode_group_stage;
  import decode_group_stage_pkg::*;

  localparam logic [31:0] ADDI_X5_7   = 32'h0070_0293;
  localparam logic [31:0] ADD_X6_X5X5 = 32'h0052_8333;
  localparam logic [31:0] ADD_X4_X3X0 = 32'h0001_8233;
  localparam logic [31:0] ADD_X4_X0X0 = 32'h0000_0233;
  localparam logic [31:0] ADDI_X1_1   = 32'h0010_0093;
  localparam logic [31:0] ADDI_X2_2   = 32'h0020_0113;
  localparam logic [31:0] ADDI_X3_3   = 32'h0030_0193;
  localparam logic [31:0] ADDI_X4_4   = 32'h0040_0213;
  localparam logic [31:0] SW_X7_0_X2  = 32'h0071_2023;
  localparam logic [31:0] ADD_X8_X7X0 = 32'h0003_8433;
  localparam logic [31:0] ADD_X9_X7X0 = 32'h0003_84B3;
  localparam logic [31:0] LUI_X1      = 32'h1234_50B7;
  localparam logic [31:0] BAD_OP      = 32'h0000_007F;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  decode_group_stage_if #(.LANES(2), .WB_PORTS(2)) bus ();

  decode_group_stage #(.LANES(2), .WB_PORTS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic [1:0] lv, input logic [31:0] p0,
                      input logic [31:0] i0, input logic [31:0] p1, input logic [31:0] i1);
    bus.in_valid  = v;
    bus.in_lane_v = lv;
    bus.in_pc[0]  = p0;
    bus.in_ir[0]  = i0;
    bus.in_pc[1]  = p1;
    bus.in_ir[1]  = i1;
  endtask

  task automatic wbw(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_en[p]   = en;
    bus.wb_addr[p] = a;
    bus.wb_data[p] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    send(1'b0, 2'b00, 0, 0, 0, 0);
    wbw(0, 1'b0, 0, 0);
    wbw(1, 1'b0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_lane_v", bus.out_lane_v, 0);
    chk("rst_illegal", bus.out_illegal, 0);
    chk("rst_dep", bus.out_dep, 0);
    chk("rst_task0", bus.out_task[0], 0);
    chk("rst_task1", bus.out_task[1], 0);

    // intra-group dependency, one-cycle latency
    send(1'b1, 2'b11, 32'h100, ADDI_X5_7, 32'h104, ADD_X6_X5X5);
    tick();
    chk("dep_valid", bus.out_valid, 1);
    chk("dep_10", bus.out_dep[1][0], 1);
    chk("dep_01", bus.out_dep[0][1], 0);
    chk("dep_rs1", bus.out_task[1].rs1_addr, 5);
    chk("dep_rs2", bus.out_task[1].rs2_addr, 5);
    chk("dep_b0", bus.out_task[0].b, 7);
    chk("dep_pc1", bus.out_task[1].pc, 32'h104);
    chk("dep_lane_v", bus.out_lane_v, 2'b11);
    chk("dep_illegal", bus.out_illegal, 0);
    send(1'b0, 2'b00, 0, 0, 0, 0);
    tick();
    chk("idle_valid", bus.out_valid, 0);

    // writeback bypass, port priority, x0 handling, lane-valid truncation
    wbw(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    send(1'b1, 2'b01, 32'h140, ADD_X4_X3X0, 32'h144, 0);
    tick();
    chk("byp_a", bus.out_task[0].a, 32'hDEAD_BEEF);
    chk("byp_lane_v", bus.out_lane_v, 2'b01);
    wbw(0, 1'b1, 5'd3, 32'h1111);
    wbw(1, 1'b1, 5'd3, 32'h2222);
    send(1'b1, 2'b01, 32'h150, ADD_X4_X3X0, 32'h154, 0);
    tick();
    chk("prio_a", bus.out_task[0].a, 32'h2222);
    wbw(0, 1'b0, 0, 0);
    wbw(1, 1'b0, 0, 0);
    send(1'b1, 2'b01, 32'h160, ADD_X4_X3X0, 32'h164, 0);
    tick();
    chk("rf_a", bus.out_task[0].a, 32'h2222);
    wbw(0, 1'b1, 5'd0, 32'h1234);
    send(1'b1, 2'b10, 32'h170, ADD_X4_X0X0, 32'h174, ADD_X4_X0X0);
    tick();
    chk("x0_a", bus.out_task[0].a, 0);
    chk("x0_lane_v", bus.out_lane_v, 2'b00);
    chk("x0_valid", bus.out_valid, 1);
    wbw(0, 1'b0, 0, 0);

    // back-to-back throughput
    send(1'b1, 2'b11, 32'h200, ADDI_X1_1, 32'h204, ADDI_X2_2);
    tick();
    chk("tp_pc0", bus.out_task[0].pc, 32'h200);
    send(1'b1, 2'b11, 32'h300, ADDI_X3_3, 32'h304, ADDI_X4_4);
    tick();
    chk("tp_pc1", bus.out_task[0].pc, 32'h300);
    chk("tp_valid", bus.out_valid, 1);
    send(1'b0, 2'b00, 0, 0, 0, 0);
    tick();

    // backpressure: OUT then SKID fill, third group refused
    bus.out_ready = 1'b0;
    send(1'b1, 2'b11, 32'h400, ADDI_X1_1, 32'h404, ADDI_X2_2);
    tick();
    chk("bp_ready1", bus.in_ready, 1);
    send(1'b1, 2'b11, 32'h500, ADDI_X3_3, 32'h504, ADDI_X4_4);
    tick();
    send(1'b1, 2'b11, 32'h600, ADDI_X1_1, 32'h604, ADDI_X2_2);
    tick();
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_pc", bus.out_task[0].pc, 32'h400);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_b1", bus.out_task[1].b, 2);
    send(1'b0, 2'b00, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_pc2", bus.out_task[0].pc, 32'h500);
    chk("bp_valid2", bus.out_valid, 1);
    chk("bp_ready2", bus.in_ready, 1);
    tick();
    chk("bp_empty", bus.out_valid, 0);

    // held refresh in OUT and SKID
    bus.out_ready = 1'b0;
    send(1'b1, 2'b11, 32'h700, SW_X7_0_X2, 32'h704, ADD_X8_X7X0);
    tick();
    chk("hr_rs2_pre", bus.out_task[0].rs2_data, 0);
    chk("hr_dep", bus.out_dep[1][0], 0);
    send(1'b1, 2'b01, 32'h800, ADD_X9_X7X0, 32'h804, 0);
    tick();
    send(1'b0, 2'b00, 0, 0, 0, 0);
    wbw(0, 1'b1, 5'd7, 32'h55);
    tick();
    chk("hr_rs2", bus.out_task[0].rs2_data, 32'h55);
    chk("hr_a1", bus.out_task[1].a, 32'h55);
    chk("hr_b0", bus.out_task[0].b, 0);
    chk("hr_valid", bus.out_valid, 1);
    chk("hr_pc", bus.out_task[0].pc, 32'h700);
    wbw(0, 1'b0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("hr_skid_a", bus.out_task[0].a, 32'h55);
    chk("hr_skid_pc", bus.out_task[0].pc, 32'h800);

    // flush with both registers full and input pending
    bus.out_ready = 1'b0;
    send(1'b1, 2'b11, 32'h900, ADDI_X1_1, 32'h904, ADDI_X2_2);
    tick();
    chk("fl_full", bus.in_ready, 0);
    flush = 1'b1;
    send(1'b1, 2'b11, 32'hA00, ADDI_X3_3, 32'hA04, ADDI_X4_4);
    tick();
    flush = 1'b0;
    send(1'b0, 2'b00, 0, 0, 0, 0);
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("fl_after", bus.out_valid, 0);
    flush = 1'b1;
    send(1'b1, 2'b11, 32'hB00, ADDI_X1_1, 32'hB04, ADDI_X2_2);
    tick();
    flush = 1'b0;
    send(1'b0, 2'b00, 0, 0, 0, 0);
    chk("fl_drop", bus.out_valid, 0);
    tick();
    chk("fl_drop2", bus.out_valid, 0);

    // illegal opcode lane next to a legal LUI
    send(1'b1, 2'b11, 32'hC00, BAD_OP, 32'hC04, LUI_X1);
    tick();
    chk("ill_vec", bus.out_illegal, 2'b01);
    chk("ill_used", {bus.out_task[0].rd_used, bus.out_task[0].rs1_used, bus.out_task[0].rs2_used}, 0);
    chk("lui_a", bus.out_task[1].a, 32'h1234_5000);
    chk("lui_used", {bus.out_task[1].rd_used, bus.out_task[1].rs1_used, bus.out_task[1].rs2_used}, 3'b100);
    send(1'b0, 2'b00, 0, 0, 0, 0);
    tick();

    // reset mid-transfer with both registers full
    bus.out_ready = 1'b0;
    wbw(0, 1'b1, 5'd5, 32'h99);
    send(1'b1, 2'b01, 32'hD00, ADDI_X5_7, 32'hD04, 0);
    tick();
    wbw(0, 1'b0, 0, 0);
    send(1'b1, 2'b01, 32'hD10, ADDI_X5_7, 32'hD14, 0);
    tick();
    send(1'b0, 2'b00, 0, 0, 0, 0);
    chk("mr_full", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async", bus.out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    send(1'b1, 2'b01, 32'hE00, ADD_X6_X5X5, 32'hE04, 0);
    tick();
    chk("mr_x5", bus.out_task[0].a, 0);
    chk("mr_pc", bus.out_task[0].pc, 32'hE00);
    send(1'b0, 2'b00, 0, 0, 0, 0);
    tick();
    chk("mr_end", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_group_stage.md
# decode_group_stage

Parametrised N-lane decode stage for the out-of-order OTTER core. It sits between fetch and the issue queue. Each cycle it accepts one fetch group of up to LANES instructions and reads operands from an internal register file, with same-cycle writeback bypass. It emits one registered group of `task_t` entries under a valid/ready handshake, backed by a one-group skid buffer. Compared with the fixed dual-lane decode it adds:
- parametrised lane and writeback-port counts;
- per-lane valid;
- backpressure;
- flush;
- illegal-opcode flagging;
- intra-group RAW dependency masks;
- operand refresh from writeback while a group is held.

## Interface
Parameters:
- LANES, 2, instructions per fetch group (1–4)
- WB_PORTS, 1, register-file write ports (1–2)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous; discards all held and incoming groups
- IN_VALID  in  1  fetch group present
- IN_READY  out  1  stage can accept a group this cycle
- IN_LANE_V  in  LANES  per-lane valid; lanes above the first 0 are ignored
- IN_PC  in  LANES×32  lane PCs
- IN_IR  in  LANES×32  lane instruction words
- WB_EN  in  WB_PORTS  writeback enables
- WB_ADDR  in  WB_PORTS×5  writeback destinations
- WB_DATA  in  WB_PORTS×32  writeback data
- OUT_VALID  out  1  task group present
- OUT_READY  in  1  issue queue accepts the group
- OUT_LANE_V  out  LANES  per-lane task valid
- OUT_TASK  out  LANES×task_t  decoded tasks
- OUT_ILLEGAL  out  LANES  lane opcode not in `opcode_t`
- OUT_DEP  out  LANES×LANES  bit [j][i] = 1 when lane j reads the rd of an older lane i<j in the same group

## Operation
- **Accept.** A group is accepted when IN_VALID & IN_READY & !FLUSH.
- **Per-lane decode.** Identical to the existing decode:
  - ALU A mux is rs1 or U-immediate.
  - ALU B mux is rs2, I-immediate, S-immediate, or PC.
  - alu_fun, wb_sel and mem_type come from funct3.
  - rd_used is 0 for BRANCH, STORE and NOP.
  - rs1_used is 0 for LUI, AUIPC, JAL and NOP.
  - rs2_used is 1 only for BRANCH, STORE and OP.
- **Illegal lanes.** An illegal lane has OUT_ILLEGAL=1 and rd_used = rs1_used = rs2_used = 0. Its remaining fields are don't-care.
- **Register-file read with bypass.**
  - If any WB port writes a nonzero address equal to the source register in the same cycle, the WB_DATA value is used.
  - If two WB ports write the same address, the higher port index wins.
  - x0 always reads 0; writes to x0 are dropped.
- **Dependency mask.** OUT_DEP[j][i] = lane_v[i] & lane_v[j] & rd_used[i] & rd_addr[i]≠0 & ((rs1_used[j] & rs1_addr[j]==rd_addr[i]) | (rs2_used[j] & rs2_addr[j]==rd_addr[i])). Bits with i ≥ j are 0.
- **Buffering.**
  - There are two group registers: OUT (visible) and SKID.
  - IN_READY = !SKID.valid.
  - An accepted group goes to OUT if OUT is empty or is being consumed this cycle; otherwise it goes to SKID.
  - On consumption, SKID moves into OUT.
- **Holding refresh.** For every held group (OUT or SKID), each cycle a WB write to a nonzero address matching a used source register of a lane overwrites:
  - A, if that lane's A mux selects rs1;
  - B, if its B mux selects rs2;
  - rs2_data.
- **Flush.** Clears OUT.valid and SKID.valid next edge and drops any concurrent input. OUT_VALID=0 and IN_READY=1 from the following cycle.

## Timing
- **Latency.** A group accepted at edge k is on OUT_* after edge k when OUT is free. Throughput is one group per cycle with OUT_READY held high.
- **Reset.**
  - OUT_VALID=0.
  - IN_READY=1 once RST_N is asserted.
  - OUT_LANE_V, OUT_ILLEGAL, OUT_DEP are all 0.
  - OUT_TASK is all 0.
  - The register file resets to 0.
  - Reset mid-transfer discards both groups.
- **Stability.** OUT_* hold stable while OUT_VALID & !OUT_READY, except for the WB refresh of operand fields.
- **IN_READY timing.** IN_READY is registered and has no combinational path from OUT_READY.
- **Simultaneous events.**
  - Accept, consume and SKID-occupied in one cycle: SKID→OUT and input→SKID.
  - FLUSH has priority over all other events.
  - A WB write in the acceptance cycle is seen through the bypass, not lost.

## Structure
- In the shared `cpu_types` package: `task_t`, `opcode_t` and the new `dec_group_t` (lane valid, task array, illegal, dep, stored A/B mux selects). Also the LANES_MAX=4 constant.
- Sub-modules:
  - Reuse `OTTER_CU_Decoder` logic per lane via generate.
  - Add `multiport_regfile`, parametrised on 2×LANES read ports and WB_PORTS write ports, with internal bypass.

## Test plan
- **Reset.** Assert RST_N low mid-stream → OUT_VALID=0 and IN_READY=1 after release, and x5 reads 0.
- **Intra-group dependency.** LANES=2, lane0 `addi x5,x0,7`, lane1 `add x6,x5,x5` → OUT_DEP[1][0]=1, lane1 rs1/rs2 = 5, one-cycle latency.
- **WB bypass.** WB writes x3=0xDEAD_BEEF in the same cycle as accepting `add x4,x3,x0` → task A = 0xDEADBEEF. A write to x0 → A stays 0.
- **Backpressure.** OUT_READY=0 for 3 cycles with IN_VALID=1:
  - group1 is in OUT and group2 in SKID, IN_READY=0, no groups lost;
  - releasing OUT_READY delivers groups 1 and 2 in order on consecutive cycles.
- **Held refresh.** A group with `sw x7,0(x2)` is stalled, then WB writes x7=0x55 → rs2_data becomes 0x55 while OUT_VALID stays high.
- **Flush and illegal lanes.**
  - FLUSH with both registers full and IN_VALID=1 → OUT_VALID=0 next cycle and nothing from the dropped group ever appears.
  - Opcode 0x7F → OUT_ILLEGAL=1 with all used bits 0.
